// File: rtl/bus_control_unit.sv
// rtl/bus_control_unit.sv - responder for sequencer READ/WRITE commands onto a 16-bit external bus
module bus_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  bus_command,
    input  logic [19:0] bus_address,
    input  logic        bus_word,
    input  logic [15:0] data_out,
    output logic [15:0] data_in,
    output logic        bus_command_done,
    output logic [18:0] mem_addr,
    output logic [1:0]  mem_byte_en,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);
    typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_DONE} state_t;

    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [19:0] addr_q, addr_d;
    logic        word_q, word_d;
    logic [15:0] wbuf_q, wbuf_d;
    logic        split_q, split_d;
    logic        second_q, second_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] data_in_q, data_in_d;
    logic        done_q, done_d;
    logic [18:0] mem_addr_q, mem_addr_d;
    logic [1:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        addr_d     = addr_q;
        word_d     = word_q;
        wbuf_d     = wbuf_q;
        split_d    = split_q;
        second_d   = second_q;
        lo_d       = lo_q;
        data_in_d  = data_in_q;
        done_d     = 1'b0;
        mem_addr_d = mem_addr_q;
        be_d       = be_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        wdata_d    = wdata_q;

        unique case (state_q)
            S_IDLE: begin
                second_d = 1'b0;
                if (bus_command == CMD_READ || bus_command == CMD_WRITE) begin
                    state_d    = S_T1;
                    write_d    = (bus_command == CMD_WRITE);
                    addr_d     = bus_address;
                    word_d     = bus_word;
                    wbuf_d     = data_out;
                    split_d    = bus_word & bus_address[0];
                    mem_addr_d = bus_address[19:1];
                    // Odd addresses always start on the high lane; a word there spills into the next word.
                    if (bus_address[0])
                        be_d = 2'b10;
                    else
                        be_d = bus_word ? 2'b11 : 2'b01;
                    if (!bus_word)
                        wdata_d = {data_out[7:0], data_out[7:0]};
                    else if (bus_address[0])
                        wdata_d = {data_out[7:0], 8'h00};
                    else
                        wdata_d = data_out;
                end
            end
            S_T1: begin
                state_d = S_T2;
                rd_d    = !write_q;
                wr_d    = write_q;
            end
            S_T2: begin
                if (!mem_ready) begin
                    rd_d = rd_q;
                    wr_d = wr_q;
                end else if (split_q && !second_q) begin
                    state_d    = S_T1;
                    second_d   = 1'b1;
                    lo_d       = mem_rdata[15:8];
                    mem_addr_d = addr_q[19:1] + 19'd1;
                    be_d       = 2'b01;
                    wdata_d    = {8'h00, wbuf_q[15:8]};
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (!write_q) begin
                        if (second_q)
                            data_in_d = {mem_rdata[7:0], lo_q};
                        else if (word_q)
                            data_in_d = mem_rdata;
                        else if (addr_q[0])
                            data_in_d = {8'h00, mem_rdata[15:8]};
                        else
                            data_in_d = {8'h00, mem_rdata[7:0]};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            write_q    <= 1'b0;
            addr_q     <= '0;
            word_q     <= 1'b0;
            wbuf_q     <= '0;
            split_q    <= 1'b0;
            second_q   <= 1'b0;
            lo_q       <= '0;
            data_in_q  <= '0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
            be_q       <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            wbuf_q     <= wbuf_d;
            split_q    <= split_d;
            second_q   <= second_d;
            lo_q       <= lo_d;
            data_in_q  <= data_in_d;
            done_q     <= done_d;
            mem_addr_q <= mem_addr_d;
            be_q       <= be_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign data_in          = data_in_q;
    assign bus_command_done = done_q;
    assign mem_addr         = mem_addr_q;
    assign mem_byte_en      = be_q;
    assign mem_rd           = rd_q;
    assign mem_wr           = wr_q;
    assign mem_wdata        = wdata_q;
endmodule
